// File: rtl/fb_fifo_pkg.sv
// Shared types and constants for the frame-buffer FIFO controller.
// The default address width here must match the paired register file.
package fb_fifo_pkg;

    localparam int FB_ADDR_WIDTH = 2;
    localparam int DEPTH         = 2 ** FB_ADDR_WIDTH;
    localparam int FB_AE_LEVEL   = 1;
    localparam int FB_AF_LEVEL   = 3;

    typedef logic [FB_ADDR_WIDTH:0] fifo_cnt_t;

    // A threshold of DEPTH is legal: almost_full at AF_LEVEL == DEPTH behaves like full.
    function automatic bit levels_ok(input int depth, input int ae, input int af);
        return (ae >= 0) && (ae <= depth) && (af >= 0) && (af <= depth);
    endfunction

endpackage

// File: rtl/fb_fifo_ctrl.sv
// Pointer/flag controller for a first-word-fall-through FIFO around a 2**ADDR_WIDTH register file.
// The head word sits at r_addr, so it is visible on the register file's r_data whenever empty is 0.
module fb_fifo_ctrl
    import fb_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int AE_LEVEL   = FB_AE_LEVEL,
    parameter int AF_LEVEL   = FB_AF_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  CW         = ADDR_WIDTH + 1;
    localparam int                  FIFO_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] AE_C       = CW'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] AF_C       = CW'(AF_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

    if (!levels_ok(FIFO_DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_levels
        $error("fb_fifo_ctrl: AE_LEVEL/AF_LEVEL must lie in 0..DEPTH");
    end

    logic                  do_rd;
    logic                  do_wr;
    logic                  ovf_set;
    logic                  unf_set;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;

    // A pop while full frees the slot that the same-cycle push lands in.
    always_comb begin
        do_rd     = rd & ~empty;
        do_wr     = wr & (~full | do_rd);
        ovf_set   = wr & full & ~rd;
        unf_set   = rd & empty;
        count_nxt = count + CW'(do_wr) - CW'(do_rd);
    end

    assign wr_en  = do_wr;
    assign w_addr = w_ptr;
    assign r_addr = r_ptr;

    // ---- registered pointers, occupancy and flags (all flags follow count_nxt) ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (do_wr) w_ptr <= w_ptr + PTR_ONE;
            if (do_rd) r_ptr <= r_ptr + PTR_ONE;
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == DEPTH_C);
            almost_empty <= (count_nxt <= AE_C);
            almost_full  <= (count_nxt >= AF_C);
            // A same-cycle set takes priority over clr_err.
            overflow     <= ovf_set | (overflow  & ~clr_err);
            underflow    <= unf_set | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_fb_fifo_ctrl.sv
// Directed bench for fb_fifo_ctrl with a behavioural register file and a data scoreboard.
module tb_fb_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DEP   = 4;
    localparam int AE_L  = 1;
    localparam int AF_L  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr, rd, clr_err;
    logic [7:0]    w_data;
    logic          wr_en;
    logic [AW-1:0] w_addr, r_addr;
    logic          empty, full, almost_empty, almost_full;
    logic [AW:0]   count;
    logic          overflow, underflow;

    logic [7:0]    mem [DEP];
    logic [7:0]    r_data;

    int            checks = 0;
    int            errors = 0;

    // Independent reference state
    int            m_count;
    int            m_w, m_r;
    logic          m_ovf, m_unf;
    logic [7:0]    sb [$];

    fb_fifo_ctrl #(.ADDR_WIDTH(AW), .AE_LEVEL(AE_L), .AF_LEVEL(AF_L)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
        .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr),
        .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_en) mem[w_addr] <= w_data;
    assign r_data = mem[r_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_w = 0; m_r = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
        sb.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"},  32'(count),        32'(m_count));
        chk({tag, ".empty"},  32'(empty),        32'(m_count == 0));
        chk({tag, ".full"},   32'(full),         32'(m_count == DEP));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(m_count <= AE_L));
        chk({tag, ".afull"},  32'(almost_full),  32'(m_count >= AF_L));
        chk({tag, ".ovf"},    32'(overflow),     32'(m_ovf));
        chk({tag, ".unf"},    32'(underflow),    32'(m_unf));
        chk({tag, ".waddr"},  32'(w_addr),       32'(m_w % DEP));
        chk({tag, ".raddr"},  32'(r_addr),       32'(m_r % DEP));
        if (m_count != 0) chk({tag, ".head"}, 32'(r_data), 32'(sb[0]));
    endtask

    // One clock: check registered state, drive inputs, check wr_en, advance the model.
    task automatic cycle(input string tag, input logic w, input logic r, input logic c,
                         input logic [7:0] d);
        logic m_empty, m_full, m_do_rd, m_do_wr;
        @(negedge clk);
        check_state(tag);
        wr = w; rd = r; clr_err = c; w_data = d;
        #1;
        m_empty = (m_count == 0);
        m_full  = (m_count == DEP);
        m_do_rd = r & ~m_empty;
        m_do_wr = w & (~m_full | m_do_rd);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(m_do_wr));
        if (m_do_rd) begin
            chk({tag, ".pop"}, 32'(r_data), 32'(sb[0]));
            void'(sb.pop_front());
        end
        if (m_do_wr) sb.push_back(d);
        m_ovf   = (w & m_full & ~r) | (m_ovf & ~c);
        m_unf   = (r & m_empty)     | (m_unf & ~c);
        m_w     = m_w + int'(m_do_wr);
        m_r     = m_r + int'(m_do_rd);
        m_count = m_count + int'(m_do_wr) - int'(m_do_rd);
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; w_data = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_state("reset");
        reset = 1'b0;

        // Fill to full, w_addr wraps back to 0
        cycle("push_a", 1, 0, 0, 8'hA1);
        cycle("push_b", 1, 0, 0, 8'hB2);
        cycle("push_c", 1, 0, 0, 8'hC3);
        cycle("push_d", 1, 0, 0, 8'hD4);
        // Rejected push while full
        cycle("ovf_e",  1, 0, 0, 8'hE5);
        cycle("clr1",   0, 0, 1, 8'h00);
        // Push and pop together while full
        cycle("full_wr_rd", 1, 1, 0, 8'hE5);
        // Drain
        cycle("pop1", 0, 1, 0, 8'h00);
        cycle("pop2", 0, 1, 0, 8'h00);
        cycle("pop3", 0, 1, 0, 8'h00);
        cycle("pop4", 0, 1, 0, 8'h00);
        cycle("unf",  0, 1, 0, 8'h00);
        cycle("clr2", 0, 0, 1, 8'h00);
        // Push and pop together while empty: write only
        cycle("empty_wr_rd", 1, 1, 0, 8'h16);
        cycle("idle1",       0, 0, 0, 8'h00);
        cycle("mid_wr_rd",   1, 1, 0, 8'h27);
        // Raise both sticky flags, then clear both
        cycle("fill1", 1, 0, 0, 8'h38);
        cycle("fill2", 1, 0, 0, 8'h49);
        cycle("fill3", 1, 0, 0, 8'h5A);
        cycle("ovf2",  1, 0, 0, 8'h6B);
        cycle("dr1",   0, 1, 0, 8'h00);
        cycle("dr2",   0, 1, 0, 8'h00);
        cycle("dr3",   0, 1, 0, 8'h00);
        cycle("dr4",   0, 1, 0, 8'h00);
        cycle("unf2",  0, 1, 0, 8'h00);
        cycle("clr3",  0, 0, 1, 8'h00);
        // Set wins over a same-cycle clear
        cycle("unf_clr", 0, 1, 1, 8'h00);
        cycle("clr4",    0, 0, 1, 8'h00);
        // Asynchronous reset mid-stream at count=2
        cycle("pre1", 1, 0, 0, 8'h7C);
        cycle("pre2", 1, 0, 0, 8'h8D);
        @(negedge clk);
        check_state("count2");
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        #1 check_state("async_rst");
        @(negedge clk);
        reset = 1'b0;
        cycle("post1", 1, 0, 0, 8'h9E);
        cycle("post2", 0, 1, 0, 8'h00);
        cycle("final", 0, 0, 0, 8'h00);
        @(negedge clk);
        check_state("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
